// File: rtl/uart_tx_scheduler.sv
// Two-requester frame scheduler for a single UART transmitter: round-robin grant,
// sends header then data byte, with a per-byte tx_done timeout.
module uart_tx_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 60000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [15:0] frame0,
    input  logic        req1,
    input  logic [15:0] frame1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        error,
    output logic        busy,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    input  logic        tx_done
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitDone,
        StGuard
    } stateT;

    stateT           stateQ, stateD;
    logic            indexQ, indexD;
    logic            grantQ, grantD;
    logic            lastGrantQ, lastGrantD;
    logic [CntW-1:0] counterQ, counterD;
    logic [15:0]     frameQ, frameD;
    logic [7:0]      txByteQ, txByteD;

    logic        accept;
    logic        pick;
    logic [15:0] pickFrame;

    assign accept    = (req0 | req1) & ~tx_active & ~tx_done;
    // Tie goes to whoever was not granted last; otherwise the sole requester wins.
    assign pick      = (req0 & req1) ? ~lastGrantQ : req1;
    assign pickFrame = pick ? frame1 : frame0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ     <= StIdle;
            indexQ     <= 1'b0;
            grantQ     <= 1'b0;
            lastGrantQ <= 1'b1;
            counterQ   <= '0;
            frameQ     <= 16'h0000;
            txByteQ    <= 8'h00;
        end else begin
            stateQ     <= stateD;
            indexQ     <= indexD;
            grantQ     <= grantD;
            lastGrantQ <= lastGrantD;
            counterQ   <= counterD;
            frameQ     <= frameD;
            txByteQ    <= txByteD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        indexD     = indexQ;
        grantD     = grantQ;
        lastGrantD = lastGrantQ;
        counterD   = counterQ;
        frameD     = frameQ;
        txByteD    = txByteQ;
        ack0       = 1'b0;
        ack1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        error      = 1'b0;
        tx_start   = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    grantD     = pick;
                    lastGrantD = pick;
                    frameD     = pickFrame;
                    indexD     = 1'b0;
                    txByteD    = pickFrame[15:8];
                    stateD     = StStart;
                end
            end
            StStart: begin
                tx_start = 1'b1;
                // The ack belongs to the header START only, the cycle after the accept.
                ack0     = ~indexQ & ~grantQ;
                ack1     = ~indexQ & grantQ;
                counterD = '0;
                stateD   = StWaitDone;
            end
            StWaitDone: begin
                if (tx_done) begin
                    stateD = StGuard;
                end else if (counterQ == CntMax) begin
                    done0  = ~grantQ;
                    done1  = grantQ;
                    error  = 1'b1;
                    stateD = StIdle;
                end else begin
                    counterD = counterQ + CntW'(1);
                end
            end
            StGuard: begin
                if (!tx_done && !tx_active) begin
                    if (!indexQ) begin
                        indexD  = 1'b1;
                        txByteD = frameQ[7:0];
                        stateD  = StStart;
                    end else begin
                        done0  = ~grantQ;
                        done1  = grantQ;
                        stateD = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign busy    = (stateQ != StIdle);
    assign tx_byte = txByteQ;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: behavioural UART transmitter model,
// byte/requester scoreboard, table-driven arbitration vectors and corner-case sequences.
module tb_uart_tx_scheduler;

    localparam int ClocksPerBit = 4;
    localparam int FrameBits    = 10;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [15:0] frame0, frame1;
    logic        ack0, ack1, done0, done1, error, busy, tx_start;
    logic [7:0]  tx_byte;
    logic        tx_active, tx_done;
    logic        txActive = 1'b0;
    logic        forceActive;

    logic        toReq0;
    logic        toLow = 1'b0;
    logic [15:0] toFrame = 16'hBEEF;
    logic        toAck0, toAck1, toDone0, toDone1, toError, toBusy, toTxStart;
    logic [7:0]  toTxByte;

    always #5 clock = ~clock;

    uart_tx_scheduler dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req0      (req0),
        .frame0    (frame0),
        .req1      (req1),
        .frame1    (frame1),
        .ack0      (ack0),
        .ack1      (ack1),
        .done0     (done0),
        .done1     (done1),
        .error     (error),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    uart_tx_scheduler #(.TIMEOUT_CYCLES(20)) dutTo (
        .clock     (clock),
        .reset_n   (reset_n),
        .req0      (toReq0),
        .frame0    (toFrame),
        .req1      (toLow),
        .frame1    (toFrame),
        .ack0      (toAck0),
        .ack1      (toAck1),
        .done0     (toDone0),
        .done1     (toDone1),
        .error     (toError),
        .busy      (toBusy),
        .tx_start  (toTxStart),
        .tx_byte   (toTxByte),
        .tx_active (toLow),
        .tx_done   (toLow)
    );

    // Transmitter model: 10 bit periods busy, then tx_done for doneLen cycles.
    int txCnt    = 0;
    int doneCnt  = 0;
    int doneLen  = 1;

    always @(posedge clock) begin
        if (txCnt == 0 && doneCnt == 0 && tx_start) begin
            txActive <= 1'b1;
            txCnt    <= FrameBits * ClocksPerBit;
        end else if (txCnt > 1) begin
            txCnt <= txCnt - 1;
        end else if (txCnt == 1) begin
            txCnt    <= 0;
            txActive <= 1'b0;
            doneCnt  <= doneLen;
        end else if (doneCnt > 0) begin
            doneCnt <= doneCnt - 1;
        end
    end

    assign tx_done   = (doneCnt != 0);
    assign tx_active = txActive | forceActive;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    // Scoreboard
    logic [7:0] expByteQ[$];
    int         expDoneQ[$];
    int         ackLog[$];
    logic [7:0] curByte = 8'h00;
    bit         startPending = 1'b0;
    int         startCnt = 0;
    int         doneSeen = 0;
    int         done1Cnt = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            startPending = 1'b0;
        end else begin
            if (ack0 | ack1) begin
                chk("ack overlap", 32'(ack0 & ack1), 0);
                ackLog.push_back(ack1 ? 1 : 0);
            end
            if (tx_start) begin
                chk("duplicate tx_start", 32'(startPending), 0);
                startPending = 1'b1;
                startCnt++;
                if (expByteQ.size() == 0) failNow("unexpected tx_start");
                else chk("tx_byte", 32'(tx_byte), 32'(expByteQ.pop_front()));
                curByte = tx_byte;
            end
            if (tx_done && busy) begin
                startPending = 1'b0;
                chk("tx_byte stable", 32'(tx_byte), 32'(curByte));
            end
            if (error && !(done0 | done1)) failNow("error without done");
            if (done0 | done1) begin
                doneSeen++;
                if (done1) done1Cnt++;
                chk("done overlap", 32'(done0 & done1), 0);
                chk("error on success", 32'(error), 0);
                if (expDoneQ.size() == 0) failNow("unexpected done");
                else chk("done requester", 32'(done1), 32'(expDoneQ.pop_front()));
            end
        end
    end

    task automatic waitAck();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (ack0 | ack1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("ack timeout");
    endtask

    task automatic waitDrain();
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (expDoneQ.size() == 0 && !busy && !tx_active && !tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("drain timeout");
        chk("bytes left", 32'(expByteQ.size()), 0);
    endtask

    task automatic pushFrame(input logic [15:0] f, input int who);
        expByteQ.push_back(f[15:8]);
        expByteQ.push_back(f[7:0]);
        expDoneQ.push_back(who);
    endtask

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] f0;
        logic [15:0] f1;
        int          grant;
        int          dLen;
    } vecT;

    vecT vecs[6];

    initial begin
        int s0, d0, d1, n;
        bit sawAck;

        vecs[0] = '{1'b1, 1'b0, 16'hA155, 16'h0000, 0, 1};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h3C7E, 1, 1};
        vecs[2] = '{1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 0, 1};
        vecs[3] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1, 2};
        vecs[4] = '{1'b0, 1'b1, 16'h9999, 16'h00FF, 1, 2};
        vecs[5] = '{1'b1, 1'b1, 16'h8001, 16'h7FFE, 0, 1};

        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        frame0 = 16'h0000;
        frame1 = 16'h0000;
        forceActive = 1'b0;
        toReq0 = 1'b0;

        repeat (3) @(negedge clock);
        chk("reset outputs", {17'h0, ack0, ack1, done0, done1, error, busy, tx_start, tx_byte}, 0);

        // Tie from reset: alternation 0,1,0,1
        req0 = 1'b1;
        req1 = 1'b1;
        frame0 = 16'hA155;
        frame1 = 16'h3C7E;
        for (int k = 0; k < 4; k++) pushFrame((k % 2 == 0) ? 16'hA155 : 16'h3C7E, k % 2);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitAck();
            if (k == 2) req0 = 1'b0;
            if (k == 3) req1 = 1'b0;
        end
        waitDrain();
        chk("tie ack count", 32'(ackLog.size()), 4);
        for (int k = 0; k < 4 && k < ackLog.size(); k++) chk("tie order", 32'(ackLog[k]), 32'(k % 2));

        // Arbitration vectors
        for (int i = 0; i < 6; i++) begin
            doneLen = vecs[i].dLen;
            frame0 = vecs[i].f0;
            frame1 = vecs[i].f1;
            req0 = vecs[i].r0;
            req1 = vecs[i].r1;
            pushFrame(vecs[i].grant == 1 ? vecs[i].f1 : vecs[i].f0, vecs[i].grant);
            s0 = startCnt;
            d0 = doneSeen;
            @(negedge clock);
            chk("vec ack0", 32'(ack0), 32'(vecs[i].grant == 0));
            chk("vec ack1", 32'(ack1), 32'(vecs[i].grant == 1));
            req0 = 1'b0;
            req1 = 1'b0;
            waitDrain();
            chk("vec tx_start count", 32'(startCnt - s0), 2);
            chk("vec done count", 32'(doneSeen - d0), 1);
        end
        doneLen = 1;

        // Frame input changes after ack must not reach tx_byte
        frame0 = 16'h5AC3;
        pushFrame(16'h5AC3, 0);
        req0 = 1'b1;
        waitAck();
        req0 = 1'b0;
        @(posedge clock);
        #1 frame0 = 16'hFFFF;
        waitDrain();

        // Reset during the data byte of a requester-1 frame
        frame1 = 16'h9D42;
        expByteQ.push_back(8'h9D);
        expByteQ.push_back(8'h42);
        s0 = startCnt;
        req1 = 1'b1;
        waitAck();
        req1 = 1'b0;
        for (int i = 0; i < 200 && startCnt < s0 + 2; i++) @(negedge clock);
        chk("reset test data start", 32'(startCnt - s0), 2);
        repeat (5) @(posedge clock);
        d1 = done1Cnt;
        #2 reset_n = 1'b0;
        forceActive = 1'b1;
        #1 chk("async reset outputs",
               {17'h0, ack0, ack1, done0, done1, error, busy, tx_start, tx_byte}, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        frame0 = 16'h1122;
        req0 = 1'b1;
        sawAck = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (ack0 | ack1) sawAck = 1'b1;
        end
        chk("ack while tx_active", 32'(sawAck), 0);
        pushFrame(16'h1122, 0);
        forceActive = 1'b0;
        waitAck();
        chk("ack0 after reset", 32'(ack0), 1);
        req0 = 1'b0;
        waitDrain();
        chk("no done1 after reset", 32'(done1Cnt - d1), 0);

        // Timeout instance: tx_done never arrives
        toReq0 = 1'b1;
        sawAck = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (toTxStart) begin
                sawAck = 1'b1;
                break;
            end
        end
        chk("timeout ack0", 32'(toAck0), 1);
        toReq0 = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n++;
            if (toDone0) break;
        end
        chk("timeout start seen", 32'(sawAck), 1);
        chk("timeout delay", 32'(n), 20);
        chk("timeout error", 32'(toError), 1);
        chk("timeout done1", 32'(toDone1), 0);
        @(negedge clock);
        chk("busy after timeout", 32'(toBusy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Parameters
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 60000, the maximum cycles to wait for tx_done per byte; it exceeds 10 bit periods at 5209 clocks/bit.

Interface
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req0  in  1  requester 0 frame request, level, held until ack0.
REQ-005 frame0  in  16  requester 0 frame; [15:8] header byte, [7:0] data byte.
REQ-006 req1  in  1  requester 1 frame request, level, held until ack1.
REQ-007 frame1  in  16  requester 1 frame, same layout as frame0.
REQ-008 ack0, ack1  out  1 each  one-cycle pulse: frame latched, requester may drop req.
REQ-009 done0, done1  out  1 each  one-cycle pulse: granted frame finished, success or timeout.
REQ-010 error  out  1  one-cycle pulse, coincident with doneX, on timeout.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-013 tx_byte  out  8  byte to transmit; stable from START through GUARD.
REQ-014 tx_active  in  1  transmitter "transmission in progress" flag.
REQ-015 tx_done  in  1  transmitter completion flag; may stay high up to 2 consecutive cycles.

Function
REQ-016 States SHALL be IDLE, START, WAIT_DONE and GUARD, with a 1-bit byte index, 1-bit grant register, 1-bit last-grant register and a timeout counter of width clog2(TIMEOUT_CYCLES).
REQ-017 IDLE, accept condition: accept only when (req0|req1) and tx_active=0 and tx_done=0; otherwise remain in IDLE.
REQ-018 IDLE, on accept:
- latch the granted frame and set index=0;
- pulse ackX for one cycle, in the same cycle as the START state;
- go to START.
REQ-019 Arbitration SHALL be round-robin.
- Single request: grant it.
- Both requesting: grant the requester not granted last.
- The last-grant register updates on every accept.
REQ-020 START SHALL last exactly one cycle.
- tx_start=1 and tx_byte=frame[15:8] when index=0, frame[7:0] when index=1.
- Clear the timeout counter and go to WAIT_DONE.
REQ-021 WAIT_DONE, on tx_done=1: go to GUARD.
REQ-022 WAIT_DONE, otherwise: increment the counter; when the counter reaches TIMEOUT_CYCLES-1 without tx_done, pulse doneX and error for the granted requester, then go to IDLE.
REQ-023 GUARD SHALL wait until tx_done=0 and tx_active=0, so the transmitter is back in idle.
- If index=0: set index=1 and go to START.
- If index=1: pulse doneX, error=0, and go to IDLE.
REQ-024 Requests arriving while busy=1 SHALL be ignored (not queued); a req held high is serviced at the next IDLE.
- Minimum gap between the done pulse and the next ack is 1 cycle.
REQ-025 The non-granted frame input SHALL never be sampled during a transaction; frame input changes after ack SHALL NOT affect tx_byte.
REQ-026 tx_start SHALL never be asserted twice without an intervening tx_done high-then-low sequence, except after a timeout.
REQ-027 Latency: req high with IDLE at edge N gives ack and tx_start high in cycle N+1; header and data bytes are sent back-to-back, separated only by the GUARD wait.

Reset
REQ-028 On reset_n=0, immediately and asynchronously:
- state=IDLE, index=0, counter=0, grant=0;
- last-grant=1, so req0 wins the first tie;
- all outputs 0, tx_byte=8'h00.
REQ-029 Reset mid-transaction SHALL abandon the frame without any done or error pulse.
- The transmitter is not reset by this block, so after reset_n rises IDLE waits for tx_active=0 and tx_done=0 before accepting (REQ-017).

Verification
REQ-030 Single frame: req0 with frame0=16'hA155 and a transmitter model (CLOKS_POR_BIT=4) -> ack0 in cycle N+1; tx_start twice; serial bytes A1 then 55; one done0 pulse; error=0.
REQ-031 Tie then alternation:
- req0 and req1 both high from reset -> order is 0,1,0,1 over four frames;
- ack and done never overlap between requesters.
REQ-032 Timeout: TIMEOUT_CYCLES=20 and a transmitter model that never raises tx_done -> done0 and error pulse together 20 cycles after tx_start; busy=0 next cycle.
REQ-033 Two-cycle tx_done: tx_done held high 2 cycles -> exactly one transition per byte, no duplicate tx_start, index advances once.
REQ-034 Reset mid-transaction: reset_n low during data byte of frame1 -> outputs 0 at once; no done1; after release with tx_active=1, no ack until tx_active=0.
REQ-035 Frame stability: frame0 changed to 16'hFFFF one cycle after ack0 -> transmitted bytes remain the originally latched values.
